music_mcu: RTL and testbench

Master control unit for the music player. It turns one-cycle play/pause and next-song button pulses, plus the song reader's song_done pulse, into the song reader's play enable, a player reset pulse and the current song index. It sits above the note-level control reader and song ROM addressing. It sequences whole songs: pause/resume, manual skip, auto-advance with a silent inter-song gap, and repeat.

---
 rtl/music_pkg.sv | 25 ++
 rtl/music_gap_timer.sv | 30 +++
 rtl/music_mcu.sv | 139 +++++++++++++
 tb/tb_music_mcu.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// music_pkg: shared encodings for the music player master control unit.
//   - state_t : FSM state encoding (RESET=0, PAUSE=1, PLAY=2, NEXT=3, GAP=4)
//   - exit_t  : where NEXT goes after its single cycle
//   - num_songs(): song count derived from the song index width
package music_pkg;

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_PAUSE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    EXIT_PAUSE = 2'd0,
    EXIT_PLAY  = 2'd1,
    EXIT_GAP   = 2'd2
  } exit_t;

  function automatic int num_songs(input int song_bits);
    return 2 ** song_bits;
  endfunction

endpackage

// File: rtl/music_gap_timer.sv
// gap_timer: down-counter timing the silent gap between auto-advanced songs.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (clears count)
//   load        - load load_value (takes priority over decrement)
//   clear       - abandon the count, return to 0 (priority over load)
//   load_value  - value loaded on load
//   zero        - count is 0
// The count sticks at 0 once reached, so zero stays high while idle.
module gap_timer #(
  parameter int GAP_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                clear,
  input  logic [GAP_BITS-1:0] load_value,
  output logic                zero
);

  logic [GAP_BITS-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear)  count <= '0;
    else if (load)       count <= load_value;
    else if (count != '0) count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/music_mcu.sv
// music_mcu: whole-song sequencer for the music player.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   play_button   - one-cycle pulse, toggle play/pause
//   next_button   - one-cycle pulse, skip to next song
//   repeat_mode   - level, replay current song when it finishes
//   song_done     - one-cycle pulse from song reader at end of song
//   play          - enable to song/control reader
//   reset_player  - one-cycle pulse restarting the song reader at address 0
//   song          - current song index (registered)
// play/reset_player are decoded from state; song only changes on the edge
// into NEXT or on reset.
module music_mcu
  import music_pkg::*;
#(
  parameter int SONG_BITS  = 2,
  parameter int GAP_CYCLES = 4,
  parameter int GAP_BITS   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play_button,
  input  logic                 next_button,
  input  logic                 repeat_mode,
  input  logic                 song_done,
  output logic                 play,
  output logic                 reset_player,
  output logic [SONG_BITS-1:0] song
);

  localparam logic [SONG_BITS-1:0] SONG_ONE  = SONG_BITS'(1);
  localparam logic [SONG_BITS-1:0] LAST_SONG = SONG_BITS'(num_songs(SONG_BITS) - 1);
  // Counter runs GAP_CYCLES-1 .. 0, one GAP cycle per value.
  localparam logic [GAP_BITS-1:0]  GAP_LOAD  =
    (GAP_CYCLES == 0) ? '0 : GAP_BITS'(GAP_CYCLES - 1);

  state_t                 state_q, state_d;
  exit_t                  exit_q, exit_d;
  logic [SONG_BITS-1:0]   song_q, song_d;
  logic                   gap_load, gap_clear, gap_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RESET;
      exit_q  <= EXIT_PAUSE;
      song_q  <= '0;
    end else begin
      state_q <= state_d;
      exit_q  <= exit_d;
      song_q  <= song_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    exit_d    = exit_q;
    song_d    = song_q;
    gap_load  = 1'b0;
    gap_clear = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_PAUSE;

      ST_PAUSE: begin
        if (next_button) begin
          state_d = ST_NEXT;
          song_d  = song_q + SONG_ONE;
          exit_d  = EXIT_PAUSE;
        end else if (play_button) begin
          state_d = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (song_done) begin
          state_d = ST_NEXT;
          if (repeat_mode) begin
            exit_d = EXIT_GAP;
          end else if (song_q != LAST_SONG) begin
            song_d = song_q + SONG_ONE;
            exit_d = EXIT_GAP;
          end else begin
            // End of playlist: rewind and stop.
            song_d = '0;
            exit_d = EXIT_PAUSE;
          end
        end else if (next_button) begin
          state_d = ST_NEXT;
          song_d  = song_q + SONG_ONE;
          exit_d  = EXIT_PLAY;
        end else if (play_button) begin
          state_d = ST_PAUSE;
        end
      end

      ST_NEXT: begin
        case (exit_q)
          EXIT_PLAY:  state_d = ST_PLAY;
          EXIT_GAP: begin
            if (GAP_CYCLES == 0) begin
              state_d = ST_PLAY;
            end else begin
              state_d  = ST_GAP;
              gap_load = 1'b1;
            end
          end
          default:    state_d = ST_PAUSE;
        endcase
      end

      ST_GAP: begin
        // next_button and song_done are deliberately ignored here.
        if (play_button) begin
          state_d   = ST_PAUSE;
          gap_clear = 1'b1;
        end else if (gap_zero) begin
          state_d = ST_PLAY;
        end
      end

      default: state_d = ST_RESET;
    endcase
  end

  gap_timer #(
    .GAP_BITS (GAP_BITS)
  ) u_gap_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (gap_load),
    .clear      (gap_clear),
    .load_value (GAP_LOAD),
    .zero       (gap_zero)
  );

  assign play         = (state_q == ST_PLAY);
  assign reset_player = (state_q == ST_RESET) || (state_q == ST_NEXT);
  assign song         = song_q;

endmodule

// File: tb/tb_music_mcu.sv
// Self-checking bench for music_mcu (SONG_BITS=2, GAP_CYCLES=4).
// Each vector holds the inputs driven during one cycle and the outputs
// expected in that same cycle (state before those inputs take effect).
module tb_music_mcu;

  logic       clk = 1'b0;
  logic       reset, play_button, next_button, repeat_mode, song_done;
  logic       play, reset_player;
  logic [1:0] song;

  int passed = 0;
  int total  = 0;

  music_mcu #(
    .SONG_BITS  (2),
    .GAP_CYCLES (4),
    .GAP_BITS   (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .play_button  (play_button),
    .next_button  (next_button),
    .repeat_mode  (repeat_mode),
    .song_done    (song_done),
    .play         (play),
    .reset_player (reset_player),
    .song         (song)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, pb, nb, dn, rep;
    logic       ep, erp;
    logic [1:0] es;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, pb, nb, dn, rep, ep, erp, input logic [1:0] es);
    vec_t v;
    v.rst = rst; v.pb = pb; v.nb = nb; v.dn = dn; v.rep = rep;
    v.ep = ep; v.erp = erp; v.es = es;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [1:0] act, exp);
    total++;
    if (act !== exp)
      $display("FAIL %s @%0d: got %0d, expected %0d", name, idx, act, exp);
    else
      passed++;
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, advance past the edge.
  task automatic cyc(input int idx, input vec_t v);
    reset = v.rst; play_button = v.pb; next_button = v.nb;
    song_done = v.dn; repeat_mode = v.rep;
    @(negedge clk);
    chk("play", idx, {1'b0, play}, {1'b0, v.ep});
    chk("reset_player", idx, {1'b0, reset_player}, {1'b0, v.erp});
    chk("song", idx, song, v.es);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t h;
    reset = 1'b1; play_button = 1'b0; next_button = 1'b0;
    song_done = 1'b0; repeat_mode = 1'b0;
    @(posedge clk);
    #1;

    //   rst pb nb dn rep   play rp song
    add(1, 0, 0, 0, 0,     0, 1, 0);  // 0  RESET (held)
    add(0, 0, 0, 0, 0,     0, 1, 0);  // 1  RESET cycle after release
    add(0, 1, 0, 0, 0,     0, 0, 0);  // 2  PAUSE, play pulse
    add(0, 0, 0, 0, 0,     1, 0, 0);  // 3  PLAY
    add(0, 1, 0, 0, 0,     1, 0, 0);  // 4  PLAY, pause pulse
    add(0, 0, 0, 0, 0,     0, 0, 0);  // 5  PAUSE
    add(0, 0, 1, 0, 0,     0, 0, 0);  // 6  PAUSE, next
    add(0, 0, 1, 0, 0,     0, 1, 1);  // 7  NEXT song1, next dropped
    add(0, 0, 0, 0, 0,     0, 0, 1);  // 8  back to PAUSE
    add(0, 1, 0, 0, 0,     0, 0, 1);  // 9  play
    add(0, 0, 1, 0, 0,     1, 0, 1);  // 10 PLAY song1, next
    add(0, 0, 0, 1, 0,     0, 1, 2);  // 11 NEXT song2, done dropped
    add(0, 0, 0, 0, 0,     1, 0, 2);  // 12 PLAY, no gap
    add(0, 0, 1, 0, 0,     1, 0, 2);  // 13 next
    add(0, 0, 0, 0, 0,     0, 1, 3);  // 14 NEXT song3
    add(0, 0, 0, 1, 0,     1, 0, 3);  // 15 PLAY last song, done
    add(0, 0, 0, 0, 0,     0, 1, 0);  // 16 NEXT wrap to 0
    add(0, 0, 0, 1, 0,     0, 0, 0);  // 17 PAUSE, done ignored
    add(0, 0, 0, 0, 0,     0, 0, 0);  // 18 PAUSE
    add(0, 1, 0, 0, 0,     0, 0, 0);  // 19 play
    add(0, 0, 1, 1, 0,     1, 0, 0);  // 20 done+next together
    add(0, 0, 0, 0, 0,     0, 1, 1);  // 21 NEXT song1 (done wins)
    add(0, 0, 1, 0, 0,     0, 0, 1);  // 22 GAP 1, next ignored
    add(0, 0, 0, 0, 0,     0, 0, 1);  // 23 GAP 2
    add(0, 0, 0, 0, 0,     0, 0, 1);  // 24 GAP 3
    add(0, 0, 0, 0, 0,     0, 0, 1);  // 25 GAP 4
    add(0, 0, 0, 0, 0,     1, 0, 1);  // 26 PLAY
    add(0, 0, 0, 1, 1,     1, 0, 1);  // 27 done with repeat
    add(0, 0, 0, 0, 1,     0, 1, 1);  // 28 NEXT, song held
    add(0, 0, 0, 0, 1,     0, 0, 1);  // 29 GAP
    add(0, 0, 0, 0, 1,     0, 0, 1);  // 30 GAP
    add(0, 0, 0, 0, 1,     0, 0, 1);  // 31 GAP
    add(0, 0, 0, 0, 1,     0, 0, 1);  // 32 GAP
    add(0, 0, 0, 0, 0,     1, 0, 1);  // 33 PLAY song1
    add(0, 0, 0, 1, 0,     1, 0, 1);  // 34 done, advance
    add(0, 0, 0, 0, 0,     0, 1, 2);  // 35 NEXT song2
    add(0, 0, 0, 0, 0,     0, 0, 2);  // 36 GAP 1
    add(0, 1, 0, 0, 0,     0, 0, 2);  // 37 GAP 2, play pulse
    add(0, 0, 0, 0, 0,     0, 0, 2);  // 38 PAUSE, song kept
    add(0, 0, 0, 0, 0,     0, 0, 2);  // 39 still PAUSE (no late PLAY)
    add(0, 1, 0, 0, 0,     0, 0, 2);  // 40 play
    add(0, 0, 0, 1, 0,     1, 0, 2);  // 41 done
    add(0, 0, 0, 0, 0,     0, 1, 3);  // 42 NEXT song3
    add(0, 0, 0, 0, 0,     0, 0, 3);  // 43 GAP 1
    add(1, 0, 0, 0, 0,     0, 0, 3);  // 44 GAP 2, reset
    add(0, 0, 0, 0, 0,     0, 1, 0);  // 45 RESET, song 0
    add(0, 0, 0, 0, 0,     0, 0, 0);  // 46 PAUSE
    add(0, 0, 0, 0, 0,     0, 0, 0);  // 47 PAUSE (gap abandoned)

    foreach (vq[i]) cyc(i, vq[i]);

    // Reset during NEXT discards the pending PLAY exit target.
    h = '{rst:0, pb:1, nb:0, dn:0, rep:0, ep:0, erp:0, es:0}; cyc(100, h); // PAUSE, play
    h = '{rst:0, pb:0, nb:1, dn:0, rep:0, ep:1, erp:0, es:0}; cyc(101, h); // PLAY, next
    h = '{rst:1, pb:0, nb:0, dn:0, rep:0, ep:0, erp:1, es:1}; cyc(102, h); // NEXT, reset
    h = '{rst:0, pb:0, nb:0, dn:0, rep:0, ep:0, erp:1, es:0}; cyc(103, h); // RESET
    h = '{rst:0, pb:0, nb:0, dn:0, rep:0, ep:0, erp:0, es:0}; cyc(104, h); // PAUSE, not PLAY
    h = '{rst:0, pb:0, nb:0, dn:0, rep:0, ep:0, erp:0, es:0}; cyc(105, h); // PAUSE

    // play_button on the last GAP cycle still pauses.
    h = '{rst:0, pb:1, nb:0, dn:0, rep:0, ep:0, erp:0, es:0}; cyc(110, h);
    h = '{rst:0, pb:0, nb:0, dn:1, rep:0, ep:1, erp:0, es:0}; cyc(111, h);
    h = '{rst:0, pb:0, nb:0, dn:0, rep:0, ep:0, erp:1, es:1}; cyc(112, h);
    h = '{rst:0, pb:0, nb:0, dn:0, rep:0, ep:0, erp:0, es:1}; cyc(113, h);
    h = '{rst:0, pb:0, nb:0, dn:0, rep:0, ep:0, erp:0, es:1}; cyc(114, h);
    h = '{rst:0, pb:0, nb:0, dn:0, rep:0, ep:0, erp:0, es:1}; cyc(115, h);
    h = '{rst:0, pb:1, nb:0, dn:0, rep:0, ep:0, erp:0, es:1}; cyc(116, h);
    h = '{rst:0, pb:0, nb:0, dn:0, rep:0, ep:0, erp:0, es:1}; cyc(117, h);
    h = '{rst:0, pb:0, nb:0, dn:0, rep:0, ep:0, erp:0, es:1}; cyc(118, h);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
